// File: rtl/dekatron_seek_ctrl.sv
// Seek initiator for a DekatronCounter: pulses Request/Dec one step at a time
// until the counter's BCD output equals a latched BCD target.
module dekatron_seek_ctrl #(
   parameter int unsigned D_NUM         = 3,
   parameter int unsigned READY_TIMEOUT = 64,
   parameter int unsigned MAX_STEPS     = 1000
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Start,
   input  logic                 Abort,
   input  logic [D_NUM*4-1:0]   Target,
   input  logic                 CntReady,
   input  logic [D_NUM*4-1:0]   CntOut,
   output logic                 CntRequest,
   output logic                 CntDec,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Error,
   output logic [15:0]          Steps
);

   localparam int unsigned DW = D_NUM * 4;
   localparam int unsigned SW = 16;
   localparam int unsigned TW = $clog2(READY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);
   localparam logic [SW-1:0] STEP_LIM = SW'(MAX_STEPS);
   localparam logic [SW-1:0] STEP_SAT = {SW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ISSUE, S_HOLD, S_WAIT, S_DONE, S_ERR
   } state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   tgt_q, tgt_d;
   logic [SW-1:0]   steps_q, steps_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            dec_q, dec_d;
   logic            req_q, req_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            abort_q, abort_d;
   logic            abort_pend;

   function automatic logic bcd_ok(input logic [DW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < D_NUM; i++) begin
         if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      steps_d    = steps_q;
      tmo_d      = tmo_q;
      dec_d      = dec_q;
      req_d      = 1'b0;
      err_d      = err_q;
      abort_d    = abort_q;
      abort_pend = abort_q | Abort;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               tgt_d   = Target;
               steps_d = '0;
               err_d   = 1'b0;
               state_d = bcd_ok(Target) ? S_CHECK : S_ERR;
            end
         end
         S_CHECK: begin
            // Unsigned compare of packed BCD equals an MSD-first digit compare
            if (Abort) begin
               state_d = S_IDLE;
            end else if (CntOut == tgt_q) begin
               state_d = S_DONE;
            end else begin
               dec_d   = (CntOut > tgt_q);
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (Abort) begin
               state_d = S_IDLE;
            end else if (steps_q == STEP_LIM) begin
               state_d = S_ERR;
            end else if (CntReady) begin
               req_d   = 1'b1;
               steps_d = (steps_q == STEP_SAT) ? steps_q : steps_q + SW'(1);
               state_d = S_HOLD;
            end else if (tmo_q >= TMO_LAST) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_HOLD: begin
            abort_d = abort_pend;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // An abort lets the in-flight step finish, then skips the recheck
            abort_d = abort_pend;
            if (CntReady) begin
               state_d = abort_pend ? S_IDLE : S_CHECK;
            end else if (tmo_q >= TMO_LAST) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) tmo_d = '0;
      if (state_d == S_IDLE) begin
         dec_d   = 1'b0;
         abort_d = 1'b0;
      end
      if (state_d == S_ERR) err_d = 1'b1;

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         tgt_q   <= '0;
         steps_q <= '0;
         tmo_q   <= '0;
         dec_q   <= 1'b0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         steps_q <= steps_d;
         tmo_q   <= tmo_d;
         dec_q   <= dec_d;
         req_q   <= req_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   assign CntRequest = req_q;
   assign CntDec     = dec_q;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign Error      = err_q;
   assign Steps      = steps_q;

endmodule

// File: tb/tb_dekatron_seek_ctrl.sv
// Directed bench for dekatron_seek_ctrl with a behavioural dekatron counter
// model and a scoreboard of expected per-seek outcomes.
module tb_dekatron_seek_ctrl;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic [11:0] Target = '0;
   logic        CntReady;
   logic [11:0] CntOut;
   logic        CntRequest, CntDec, Busy, Done, Error;
   logic [15:0] Steps;

   always #5 Clk = ~Clk;

   dekatron_seek_ctrl #(.D_NUM(3), .READY_TIMEOUT(64), .MAX_STEPS(1000)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort), .Target(Target),
      .CntReady(CntReady), .CntOut(CntOut), .CntRequest(CntRequest), .CntDec(CntDec),
      .Busy(Busy), .Done(Done), .Error(Error), .Steps(Steps)
   );

   typedef struct packed {
      logic        done;
      logic        err;
      logic [15:0] steps;
      logic [11:0] out;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   // Counter model configuration
   int   lat_cfg = 1;
   int   top_cfg = 999;
   int   fault_at = 0;
   logic m_load = 1'b0;
   int   m_load_val = 0;

   int   m_val = 0;
   int   m_lat = 0;
   int   m_n = 0;
   logic m_ready = 1'b1;
   logic m_stuck = 1'b0;
   logic m_dir = 1'b0;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   assign CntReady = m_ready;
   assign CntOut   = to_bcd(m_val);

   always @(posedge Clk) begin
      if (m_load) begin
         m_val   <= m_load_val;
         m_ready <= 1'b1;
         m_stuck <= 1'b0;
         m_lat   <= 0;
         m_n     <= 0;
      end else if (m_ready) begin
         if (CntRequest) begin
            m_ready <= 1'b0;
            m_dir   <= CntDec;
            m_n     <= m_n + 1;
            m_stuck <= (fault_at != 0) && (m_n + 1 == fault_at);
            m_lat   <= lat_cfg;
         end
      end else if (!m_stuck) begin
         if (m_lat == 0) begin
            m_ready <= 1'b1;
            if (m_dir) m_val <= (m_val == 0) ? top_cfg : m_val - 1;
            else       m_val <= (m_val == top_cfg) ? 0 : m_val + 1;
         end else begin
            m_lat <= m_lat - 1;
         end
      end
   end

   // Observation counters
   int   req_tot = 0;
   int   dec_bad_tot = 0;
   int   done_tot = 0;
   logic exp_dir = 1'b0;

   always @(posedge Clk) begin
      if (CntRequest === 1'b1) begin
         req_tot <= req_tot + 1;
         if (CntDec !== exp_dir) dec_bad_tot <= dec_bad_tot + 1;
      end
      if (Done === 1'b1) done_tot <= done_tot + 1;
   end

   int base_req, base_dec, base_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic d, input logic e, input int s, input logic [11:0] o);
      exp_t r;
      r.done  = d;
      r.err   = e;
      r.steps = 16'(s);
      r.out   = o;
      return r;
   endfunction

   task automatic load(input int v);
      @(negedge Clk);
      m_load_val = v;
      m_load     = 1'b1;
      @(negedge Clk);
      m_load     = 1'b0;
   endtask

   task automatic start_seek(input logic [11:0] tgt, input logic with_abort);
      base_req  = req_tot;
      base_dec  = dec_bad_tot;
      base_done = done_tot;
      @(negedge Clk);
      Target = tgt;
      Start  = 1'b1;
      Abort  = with_abort;
      @(negedge Clk);
      Start  = 1'b0;
      Abort  = 1'b0;
      Target = 12'($urandom);
   endtask

   task automatic finish_seek(input string tag, input int budget);
      exp_t e;
      int   n;
      n = 0;
      while (Busy === 1'b1 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      check({tag, "_busy_end"}, 32'(Busy), 32'd0);
      e = sb.pop_front();
      check({tag, "_done_cnt"}, 32'(done_tot - base_done), 32'(e.done));
      check({tag, "_error"},    32'(Error),                32'(e.err));
      check({tag, "_steps"},    32'(Steps),                32'(e.steps));
      check({tag, "_req_cnt"},  32'(req_tot - base_req),   32'(e.steps));
      check({tag, "_cnt_out"},  32'(CntOut),               32'(e.out));
      check({tag, "_dec_dir"},  32'(dec_bad_tot - base_dec), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req"},   32'(CntRequest), 32'd0);
      check({tag, "_dec"},   32'(CntDec),     32'd0);
      check({tag, "_busy"},  32'(Busy),       32'd0);
      check({tag, "_done"},  32'(Done),       32'd0);
      check({tag, "_error"}, 32'(Error),      32'd0);
      check({tag, "_steps"}, 32'(Steps),      32'd0);
   endtask

   initial begin
      int n;

      repeat (3) @(negedge Clk);
      check_idle_outputs("rst_low");
      Rst_n = 1'b1;
      @(negedge Clk);
      check_idle_outputs("rst_rel");

      // Up-seek 000 -> 047, with first-request timing
      top_cfg = 999; lat_cfg = 1; exp_dir = 1'b0;
      load(0);
      sb.push_back(mk(1'b1, 1'b0, 47, 12'h047));
      start_seek(12'h047, 1'b0);
      check("up_busy_e0", 32'(Busy), 32'd1);
      check("up_req_e0",  32'(CntRequest), 32'd0);
      @(negedge Clk);
      check("up_req_e1",  32'(CntRequest), 32'd0);
      @(negedge Clk);
      check("up_req_e2",  32'(CntRequest), 32'd1);
      check("up_steps_e2", 32'(Steps), 32'd1);
      @(negedge Clk);
      check("up_req_e3",  32'(CntRequest), 32'd0);
      finish_seek("up", 2000);

      // Down-seek 047 -> 009
      exp_dir = 1'b1;
      sb.push_back(mk(1'b1, 1'b0, 38, 12'h009));
      start_seek(12'h009, 1'b0);
      finish_seek("down", 2000);

      // Invalid BCD target
      exp_dir = 1'b0;
      load(50);
      sb.push_back(mk(1'b0, 1'b1, 0, 12'h050));
      start_seek(12'h0A5, 1'b0);
      finish_seek("invalid", 50);

      // Already at target; Start+Abort together, Start wins and clears Error
      load(123);
      sb.push_back(mk(1'b1, 1'b0, 0, 12'h123));
      start_seek(12'h123, 1'b1);
      check("eq_err_clr", 32'(Error), 32'd0);
      check("eq_done_e0", 32'(Done),  32'd0);
      check("eq_busy_e0", 32'(Busy),  32'd1);
      @(negedge Clk);
      check("eq_done_e1", 32'(Done),  32'd1);
      @(negedge Clk);
      check("eq_done_e2", 32'(Done),  32'd0);
      check("eq_busy_e2", 32'(Busy),  32'd0);
      finish_seek("equal", 10);

      // Counter stops answering after the 3rd request
      fault_at = 3; exp_dir = 1'b0;
      load(0);
      sb.push_back(mk(1'b0, 1'b1, 3, 12'h002));
      start_seek(12'h047, 1'b0);
      finish_seek("hs_fault", 1000);
      fault_at = 0;

      // Abort during WAIT of step 5
      lat_cfg = 2;
      load(0);
      sb.push_back(mk(1'b0, 1'b0, 5, 12'h005));
      start_seek(12'h047, 1'b0);
      n = 0;
      while ((req_tot - base_req) < 5 && n < 1000) begin
         @(negedge Clk);
         n++;
      end
      check("abort_reach5", 32'(req_tot - base_req), 32'd5);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      finish_seek("abort", 200);

      // Reset pulse mid-seek
      lat_cfg = 1;
      load(0);
      start_seek(12'h047, 1'b0);
      repeat (20) @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (4) @(negedge Clk);
      check_idle_outputs("rst_after");

      // Unreachable target on a counter topping out at 255
      top_cfg = 255; lat_cfg = 0; exp_dir = 1'b0;
      load(0);
      sb.push_back(mk(1'b0, 1'b1, 1000, to_bcd(1000 % 256)));
      start_seek(12'h300, 1'b0);
      finish_seek("max_steps", 20000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dekatron_seek_ctrl.md
# dekatron_seek_ctrl

Sequencing initiator for a `DekatronCounter`. It accepts a BCD target value and drives the counter's `Request`/`Dec` handshake one step at a time, re-reading the counter's `Out` after each step, until the counter equals the target. It sits between the program-control logic (IP/AP seek, loop jumps) and any counter instance, replacing hand-written request pulsing. It reports completion, step count and failure: invalid target, lost handshake, or an unreachable target.

## Interface

Parameters:
- `D_NUM`, 3: number of dekatrons (BCD digits) in the attached counter.
- `READY_TIMEOUT`, 64: maximum `Clk` cycles to wait for `CntReady` in ISSUE or WAIT before flagging an error.
- `MAX_STEPS`, 1000: maximum requests per seek before flagging an error.

Ports:
- `Clk` in 1: single clock, rising edge. This is the same clock the counter uses.
- `Rst_n` in 1: reset, asynchronous assert, active-low.
- `Start` in 1: begin a seek. Sampled only in IDLE.
- `Abort` in 1: cancel the current seek.
- `Target` in `D_NUM*4`: BCD target, latched on an accepted `Start`.
- `CntReady` in 1: counter `Ready`.
- `CntOut` in `D_NUM*4`: counter `Out`, in BCD.
- `CntRequest` out 1: counter `Request`. Registered, one-cycle pulse.
- `CntDec` out 1: counter `Dec`. Registered.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse on successful completion.
- `Error` out 1: sticky failure flag.
- `Steps` out 16: number of requests issued in the current or last seek.

## Operation

Reset:
- State = IDLE.
- All outputs are 0, and the latched target is 0.

States and transitions:
- **IDLE**
  - `Start`=1: latch `Target`, clear `Steps`, `Error` and the timeout counter, then go to CHECK.
  - If any latched digit is >9, go to ERR instead.
- **CHECK**
  - Compare `CntOut` to the latched target as BCD magnitudes, most significant digit first.
  - Equal: go to DONE.
  - Otherwise: set `CntDec` = (`CntOut` > target), then go to ISSUE.
- **ISSUE**
  - `CntReady`=1: assert `CntRequest` for the next cycle, increment `Steps`, go to HOLD.
  - Otherwise: wait and count toward the timeout.
  - Before issuing, if `Steps`==`MAX_STEPS`, go to ERR instead.
- **HOLD**
  - Lasts exactly one cycle. `CntRequest` returns to 0.
  - `CntReady` is ignored here, because the counter may not yet have dropped it.
  - Go to WAIT.
- **WAIT**
  - `CntReady`=1: go to CHECK.
  - Otherwise: count toward the timeout.
- **DONE**
  - `Done`=1 for one cycle, then go to IDLE.
- **ERR**
  - Set `Error`=1, `Busy`=0, then go to IDLE.
  - `Error` stays 1 until the next accepted `Start`.

`CntDec` handling:
- Changes only on the CHECK exit.
- Held stable through ISSUE, HOLD and WAIT.
- Cleared on return to IDLE.

Timeout:
- The counter resets on every state change.
- Reaching `READY_TIMEOUT` in ISSUE or WAIT goes to ERR.

Abort:
- In CHECK or ISSUE: go to IDLE on the next edge. No new request is issued, and `Done`=0.
- In HOLD or WAIT: the request already in flight completes; the block goes to IDLE when it would otherwise enter CHECK.
- `Error` is not set by an abort.

Other boundary conditions:
- `Start` while `Busy` is ignored.
- `Start` and `Abort` asserted together in IDLE: `Start` wins and `Abort` is ignored.
- `Steps` saturates at 16'hFFFF.
- `Target` changes after latch have no effect.
- No wrap-around path is used; direction is always by magnitude.
  - A target above the counter's top limit makes the counter wrap and oscillate; `MAX_STEPS` terminates this as ERR.

## Timing

Let E0 be the edge that samples `Start`.
- State = CHECK after E0.
- If `CntOut` equals the target at E1: `Done` is high between E1 and E2. Zero requests are issued.
- Otherwise, with `CntReady`=1 at E2: `CntRequest` is high between E2 and E3 only.
- Per-step cost is 4 cycles plus the counter's ready latency: CHECK, ISSUE, HOLD, then ≥1 WAIT cycle.
- `Busy` rises at E0 and falls on the edge that leaves DONE or ERR.
- `Rst_n` low mid-seek:
  - All outputs clear immediately, and a request pulse is truncated.
  - After release, the block stays in IDLE until a new `Start`.

## Test plan

- **Up-seek:** counter at 000, `Target`=12'h047 → 47 requests with `CntDec`=0, counter ends at 047, `Done` one pulse, `Steps`=47, `Error`=0.
- **Down-seek:** counter at 047, `Target`=12'h009 → 38 requests with `CntDec`=1, counter ends at 009, `Steps`=38.
- **Already at target:** counter at 123, `Target`=12'h123 → `Done` between E1 and E2, `CntRequest` never high, `Steps`=0.
- **Invalid target:** `Target`=12'h0A5 → ERR, `Error`=1, no requests. A following valid `Start` clears `Error`.
- **Handshake fault:** counter model holds `Ready`=0 after the 3rd request → `Error`=1 after `READY_TIMEOUT` cycles in WAIT, `Steps`=3.
- **Abort and reset:**
  - `Abort` during WAIT of step 5 → that step completes, then IDLE, `Steps`=5, `Done`=0, `Error`=0.
  - `Rst_n` pulse mid-seek → all outputs 0.
  - `Target`=12'h300 with `TOP_VALUE` 255 → `Error` after `MAX_STEPS` requests.
